// File: rtl/riscv_dcache_pkg.sv
// dcache_pkg: shared types and geometry for the RISC-V data cache.
//   dcacheState_t : controller states (IDLE, FILL, WRITE)
//   LINE_BITS     : cache line width (4 x 32-bit words)
//   indexWidth()/tagWidth() : address-field widths derived from the line count
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE
  } dcacheState_t;

  localparam int unsigned WORD_BITS = 32;
  localparam int unsigned LINE_BITS = 128;
  localparam int unsigned BYTE_W    = 2;
  localparam int unsigned OFFSET_W  = 2;

  function automatic int unsigned indexWidth(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tagWidth(input int unsigned lines);
    return 32 - BYTE_W - OFFSET_W - $clog2(lines);
  endfunction

endpackage

// File: rtl/riscv_dcache_array.sv
// dcache_array: valid/tag/data storage for the direct-mapped data cache.
//   index/offset  : line and word select (combinational read by index)
//   fillEn        : write whole line + tag, set valid (synchronous)
//   wordEn        : write one word of the indexed line (synchronous)
//   reset         : synchronous clear of all valid bits; tags/data untouched
//   lineValid/lineTag/lineData : contents of the indexed line
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned LINES      = 4,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned TAG_W      = 26
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [IDX_W-1:0]                 index,
  input  logic [OFFSET_W-1:0]              offset,
  input  logic                             fillEn,
  input  logic [TAG_W-1:0]                 fillTag,
  input  logic [LINE_WORDS*WORD_BITS-1:0]  fillLine,
  input  logic                             wordEn,
  input  logic [WORD_BITS-1:0]             wordData,
  output logic                             lineValid,
  output logic [TAG_W-1:0]                 lineTag,
  output logic [LINE_WORDS*WORD_BITS-1:0]  lineData
);

  logic [LINES-1:0]                         validQ;
  logic [TAG_W-1:0]                         tagMem  [LINES];
  logic [LINE_WORDS-1:0][WORD_BITS-1:0]     dataMem [LINES];

  always_ff @(posedge clk) begin
    if (reset) begin
      validQ <= '0;
    end else if (fillEn) begin
      validQ[index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fillEn) begin
      tagMem[index]  <= fillTag;
      dataMem[index] <= fillLine;
    end else if (wordEn) begin
      dataMem[index][offset] <= wordData;
    end
  end

  assign lineValid = validQ[index];
  assign lineTag   = tagMem[index];
  assign lineData  = dataMem[index];

endmodule

// File: rtl/riscv_dcache.sv
// riscv_dcache: direct-mapped, write-through, no-write-allocate data cache.
//   load/store/addr/wdata : core data-memory request (held while dhit=0)
//   rdata/dhit            : load data and access-complete (stall release)
//   mem_req/mem_we/mem_addr/mem_wdata : registered backing-memory request
//   mem_rdata/mem_ack     : fill line and one-cycle completion pulse
module riscv_dcache
  import dcache_pkg::*;
#(
  parameter int unsigned LINES      = 4,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  store,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  dhit,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [LINE_BITS-1:0]  mem_rdata,
  input  logic                  mem_ack
);

  localparam int unsigned IDX_W = indexWidth(LINES);
  localparam int unsigned TAG_W = tagWidth(LINES);

  dcacheState_t state, nextState;

  logic [IDX_W-1:0]                     index;
  logic [TAG_W-1:0]                     tag;
  logic [OFFSET_W-1:0]                  offset;
  logic                                 lineValid;
  logic [TAG_W-1:0]                     lineTag;
  logic [LINE_BITS-1:0]                 lineData;
  logic [LINE_WORDS-1:0][WORD_BITS-1:0] lineWords;
  logic                                 hit;
  logic                                 ackSeen;
  logic                                 fillEn;
  logic                                 wordEn;
  logic                                 unusedByteBits;

  logic        memReqQ;
  logic        memWeQ;
  logic [31:0] memAddrQ;
  logic [31:0] memWdataQ;

  assign offset         = addr[3:2];
  assign index          = addr[4 +: IDX_W];
  assign tag            = addr[31 -: TAG_W];
  assign unusedByteBits = ^addr[1:0];

  dcache_array #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W)
  ) uArray (
    .clk       (clk),
    .reset     (reset),
    .index     (index),
    .offset    (offset),
    .fillEn    (fillEn),
    .fillTag   (tag),
    .fillLine  (mem_rdata),
    .wordEn    (wordEn),
    .wordData  (wdata),
    .lineValid (lineValid),
    .lineTag   (lineTag),
    .lineData  (lineData)
  );

  assign lineWords = lineData;
  assign hit       = lineValid && (lineTag == tag);
  // acks are only meaningful while our own request is outstanding
  assign ackSeen   = memReqQ && mem_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    dhit      = 1'b0;
    fillEn    = 1'b0;
    wordEn    = 1'b0;
    unique case (state)
      IDLE: begin
        if (store) begin
          nextState = WRITE;
        end else if (load && !hit) begin
          nextState = FILL;
        end else begin
          dhit = 1'b1;
        end
      end
      FILL: begin
        if (ackSeen) begin
          nextState = IDLE;
          fillEn    = 1'b1;
        end
      end
      WRITE: begin
        if (ackSeen) begin
          nextState = IDLE;
          dhit      = 1'b1;
          wordEn    = hit;
        end
      end
      default: nextState = IDLE;
    endcase
    if (reset) begin
      dhit   = 1'b1;
      fillEn = 1'b0;
      wordEn = 1'b0;
    end
  end

  assign rdata = (!reset && state == IDLE && load && !store && hit) ? lineWords[offset] : '0;

  // Stores issue the request on the IDLE->WRITE edge; a fill issues it one
  // cycle after entering FILL, which is what gives a load miss its extra
  // stall cycle relative to a store.
  always_ff @(posedge clk) begin
    if (reset) begin
      memReqQ   <= 1'b0;
      memWeQ    <= 1'b0;
      memAddrQ  <= '0;
      memWdataQ <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (store) begin
            memReqQ   <= 1'b1;
            memWeQ    <= 1'b1;
            memAddrQ  <= {addr[31:2], 2'b00};
            memWdataQ <= wdata;
          end
        end
        FILL: begin
          if (!memReqQ) begin
            memReqQ  <= 1'b1;
            memWeQ   <= 1'b0;
            memAddrQ <= {addr[31:4], 4'b0000};
          end else if (mem_ack) begin
            memReqQ <= 1'b0;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            memReqQ <= 1'b0;
          end
        end
        default: memReqQ <= 1'b0;
      endcase
    end
  end

  assign mem_req   = memReqQ;
  assign mem_we    = memWeQ;
  assign mem_addr  = memAddrQ;
  assign mem_wdata = memWdataQ;

endmodule

// File: tb/tb_riscv_dcache.sv
module tb_riscv_dcache;

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic         store;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         dhit;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ack;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] LINE_A = 128'h00004444_00003333_00002222_00001111;
  localparam logic [127:0] LINE_B = 128'hB000000B_B000000A_B0000009_B0000008;
  localparam logic [127:0] LINE_C = 128'hC0000004_C0000003_C0000002_C0000001;
  localparam logic [127:0] LINE_D = 128'hD0000004_D0000003_D0000002_D0000001;

  riscv_dcache #(
    .LINES      (4),
    .LINE_WORDS (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .store     (store),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .dhit      (dhit),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
  endtask

  // Plays backing memory for one access: acks on the ackAfter-th cycle of
  // mem_req and counts cycles with dhit low. Returns at the dhit=1 cycle,
  // sampled mid-cycle, before that cycle's rising edge.
  task automatic runAccess(input int ackAfter, input logic [127:0] line, output int lowCycles,
                           output logic sawWe, output logic [31:0] sawAddr,
                           output logic [31:0] sawWdata, output logic sawRead);
    int  reqCycles;
    bit  finished;
    reqCycles = 0;
    lowCycles = 0;
    finished  = 1'b0;
    sawWe     = 1'b0;
    sawAddr   = '0;
    sawWdata  = '0;
    sawRead   = 1'b0;
    for (int c = 0; c < 40 && !finished; c++) begin
      @(negedge clk);
      if (mem_req) begin
        reqCycles++;
        sawWe    = mem_we;
        sawAddr  = mem_addr;
        sawWdata = mem_wdata;
        if (!mem_we) sawRead = 1'b1;
        if (reqCycles == ackAfter) begin
          mem_ack   = 1'b1;
          mem_rdata = line;
        end
      end
      #1;
      if (dhit) finished = 1'b1;
      else lowCycles++;
      if (!finished) tick();
    end
    if (!finished) checkEq("access_timeout", 32'd0, 32'd1);
  endtask

  int          low;
  logic        we;
  logic [31:0] ma;
  logic [31:0] mwd;
  logic        rd;

  initial begin
    reset     = 1'b1;
    load      = 1'b0;
    store     = 1'b0;
    addr      = '0;
    wdata     = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checkEq("rst_mem_req",   {31'd0, mem_req}, 32'd0);
    checkEq("rst_mem_we",    {31'd0, mem_we},  32'd0);
    checkEq("rst_mem_addr",  mem_addr,         32'd0);
    checkEq("rst_mem_wdata", mem_wdata,        32'd0);
    checkEq("rst_dhit",      {31'd0, dhit},    32'd1);
    checkEq("rst_rdata",     rdata,            32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkEq("idle_dhit", {31'd0, dhit}, 32'd1);
    tick();

    // load miss at 0x40, ack after 3 request cycles
    load = 1'b1; addr = 32'h40;
    runAccess(3, LINE_A, low, we, ma, mwd, rd);
    checkEq("fill_low_cycles", low, 32'd5);
    checkEq("fill_we",   {31'd0, we}, 32'd0);
    checkEq("fill_addr", ma, 32'h40);
    checkEq("fill_rdata", rdata, 32'h00001111);
    tick();
    addr = 32'h44;
    @(negedge clk);
    checkEq("hit44_dhit",  {31'd0, dhit}, 32'd1);
    checkEq("hit44_rdata", rdata, 32'h00002222);
    checkEq("hit44_noreq", {31'd0, mem_req}, 32'd0);
    tick();

    // store hit at 0x48, ack after 2
    load = 1'b0; store = 1'b1; addr = 32'h48; wdata = 32'hDEADBEEF;
    runAccess(2, '0, low, we, ma, mwd, rd);
    checkEq("st48_low",   low, 32'd2);
    checkEq("st48_we",    {31'd0, we}, 32'd1);
    checkEq("st48_addr",  ma, 32'h48);
    checkEq("st48_wdata", mwd, 32'hDEADBEEF);
    tick();
    store = 1'b0; load = 1'b1; addr = 32'h48;
    @(negedge clk);
    checkEq("ld48_dhit",  {31'd0, dhit}, 32'd1);
    checkEq("ld48_rdata", rdata, 32'hDEADBEEF);
    tick();
    addr = 32'h40;
    @(negedge clk);
    checkEq("ld40_rdata", rdata, 32'h00001111);
    tick();

    // store miss at 0x80: write only, no allocate
    load = 1'b0; store = 1'b1; addr = 32'h80; wdata = 32'h12345678;
    runAccess(1, '0, low, we, ma, mwd, rd);
    checkEq("st80_low",  low, 32'd1);
    checkEq("st80_we",   {31'd0, we}, 32'd1);
    checkEq("st80_addr", ma, 32'h80);
    tick();
    store = 1'b0; load = 1'b1; addr = 32'h80;
    runAccess(1, LINE_B, low, we, ma, mwd, rd);
    checkEq("ld80_low",   low, 32'd3);
    checkEq("ld80_addr",  ma, 32'h80);
    checkEq("ld80_we",    {31'd0, we}, 32'd0);
    checkEq("ld80_rdata", rdata, 32'hB0000008);
    tick();

    // index conflict: 0x40 was evicted by 0x80, 0x140 evicts it again
    addr = 32'h40;
    runAccess(1, LINE_A, low, we, ma, mwd, rd);
    checkEq("re40_low", low, 32'd3);
    tick();
    addr = 32'h14C;
    runAccess(1, LINE_C, low, we, ma, mwd, rd);
    checkEq("ld140_low",   low, 32'd3);
    checkEq("ld140_addr",  ma, 32'h140);
    checkEq("ld140_rdata", rdata, 32'hC0000004);
    tick();
    addr = 32'h40;
    runAccess(1, LINE_A, low, we, ma, mwd, rd);
    checkEq("again40_low",   low, 32'd3);
    checkEq("again40_rdata", rdata, 32'h00001111);
    tick();

    // reset during the second FILL cycle, late ack must be ignored
    load = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load = 1'b1; addr = 32'h40;
    tick();                       // IDLE miss cycle
    tick();                       // FILL, no request yet
    reset = 1'b1;                 // FILL cycle 2, request up
    @(negedge clk);
    checkEq("midrst_req_up", {31'd0, mem_req}, 32'd1);
    checkEq("midrst_dhit",   {31'd0, dhit},    32'd1);
    checkEq("midrst_rdata",  rdata,            32'd0);
    tick();
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = LINE_D;
    @(negedge clk);
    checkEq("postrst_req",  {31'd0, mem_req}, 32'd0);
    checkEq("postrst_miss", {31'd0, dhit},    32'd0);
    tick();
    runAccess(1, LINE_D, low, we, ma, mwd, rd);
    checkEq("postrst_low",   low, 32'd2);
    checkEq("postrst_rdata", rdata, 32'hD0000001);
    tick();

    // simultaneous load and store at 0x10: write only
    load = 1'b1; store = 1'b1; addr = 32'h10; wdata = 32'hCAFEF00D;
    runAccess(1, LINE_C, low, we, ma, mwd, rd);
    checkEq("ldst_we",      {31'd0, we}, 32'd1);
    checkEq("ldst_addr",    ma, 32'h10);
    checkEq("ldst_wdata",   mwd, 32'hCAFEF00D);
    checkEq("ldst_no_fill", {31'd0, rd}, 32'd0);
    tick();
    load = 1'b0; store = 1'b0;
    @(negedge clk);
    checkEq("ldst_idle_req", {31'd0, mem_req}, 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/riscv_dcache.md
# riscv_dcache

Direct-mapped, write-through, no-write-allocate data cache that answers the pipelined RISC-V core's data-memory port (load strobe, ALU address, store data, store strobe in; read data and `dhit` out). It stalls the core by deasserting `dhit` on misses and stores, and fetches lines from or writes words to backing memory over a req/ack handshake.

## Interface
- `LINES`, 4: number of cache lines; power of two, at least 2.
- `LINE_WORDS`, 4: 32-bit words per line; fixed at 4, giving a 128-bit line.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `load`  in  1  core load request (the core's `LoadM`).
- `store`  in  1  core store request (the core's `MemWrite`).
- `addr`  in  32  byte address (the core's `ALUOut`); `addr[1:0]` ignored.
- `wdata`  in  32  store data (the core's `WriteData`).
- `rdata`  out  32  load data; valid only while `load && dhit`.
- `dhit`  out  1  access complete this cycle; drives the core's `dhit`.
- `mem_req`  out  1  backing-memory request.
- `mem_we`  out  1  1 = word write, 0 = line read.
- `mem_addr`  out  32  line-aligned address for reads; word address for writes.
- `mem_wdata`  out  32  write word.
- `mem_rdata`  in  128  fill line; word *k* at bits `[32k+31:32k]`.
- `mem_ack`  in  1  one-cycle completion pulse from memory.

## Operation
- Address split: offset `addr[3:2]`; index `addr[3+log2(LINES):4]`; tag is the remaining upper bits.
- Per-line storage: valid bit, tag, and 4 data words.
- FSM states: IDLE, FILL, WRITE.
- IDLE, no request: `dhit`=1 so the core is not stalled.
- IDLE, `load` hit: `dhit`=1 and `rdata` = selected word, both combinational in the same cycle; state stays IDLE.
- IDLE, `load` miss: `dhit`=0; next state is FILL.
- IDLE, `store`: `dhit`=0; next state is WRITE. `store` takes priority over a simultaneous `load`.
- FILL: drive `mem_req`=1, `mem_we`=0, and `mem_addr` = `{addr[31:4],4'b0}`. On `mem_ack`, write `mem_rdata` into the line, set valid, write the tag, and return to IDLE. The core is still presenting the load, so the access then hits.
- WRITE: drive `mem_req`=1, `mem_we`=1, `mem_addr` = `{addr[31:2],2'b0}`, and `mem_wdata` = `wdata`. On `mem_ack`, `dhit`=1 combinationally; if the line hits, update its word at the same edge; return to IDLE. A store miss does not allocate.
- The core holds `load`/`store`/`addr`/`wdata` stable while `dhit`=0. The cache does not re-register these inputs.

## Timing
- Reset: state becomes IDLE and all valid bits clear.
  - Output values during and after reset: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `dhit`=1, `rdata`=0.
  - Data and tag arrays are not reset.
- Load hit latency: 0 cycles.
- Load miss: `dhit` low for 1 + N + 1 cycles, where N = memory cycles from `mem_req` rising to `mem_ack`, inclusive.
- Store: `dhit` low for 1 + (N−1) cycles, then high in the `mem_ack` cycle.
- Handshake:
  - `mem_req` is registered.
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are stable from the request until `mem_ack`.
  - `mem_req` drops on the edge following `mem_ack`.
  - An ack arriving while `mem_req`=0 is ignored.
- Reset mid-FILL or mid-WRITE: the FSM aborts to IDLE and `mem_req` drops at that edge. Backing memory must tolerate a request withdrawn without ack. A partially completed fill never sets valid.
- Index wrap: addresses that differ only in the tag map to the same line. A fill overwrites the previous contents unconditionally.

## Structure
- Shared package `dcache_pkg`:
  - state enum `{IDLE, FILL, WRITE}`;
  - offset/index/tag width constants derived from `LINES`;
  - constant `LINE_BITS = 128`.
- One sub-module, `dcache_array`, holds valid/tag/data storage:
  - combinational read by index;
  - synchronous line write (fill) and word write (store hit);
  - synchronous valid clear on `reset`.
- The top level holds the FSM, hit compare, and memory-port registers.

## Test plan
- After reset, `load`=1 at `addr`=0x40, memory ack after 3 cycles with line 0x4444_3333_2222_1111 (128-bit, word0=0x1111) → `dhit`=0 for 5 cycles, then `rdata`=0x00001111 and `dhit`=1; a repeat load at 0x44 → `dhit`=1 same cycle, `rdata`=word1.
- Store 0xDEADBEEF to 0x48 (line cached), ack after 2 cycles → `mem_we`=1, `mem_addr`=0x48, `dhit`=1 in the ack cycle; a following load at 0x48 hits with `rdata`=0xDEADBEEF.
- Store to 0x80 (uncached) → memory write issued; a subsequent load at 0x80 misses (no allocate) and triggers FILL at `mem_addr`=0x80.
- Conflict: fill 0x40, then load 0x140 (LINES=4, same index) → miss and refill; a later load at 0x40 misses again.
- Reset asserted in the second cycle of FILL, with ack arriving one cycle later → `mem_req`=0 after the reset edge, ack ignored, load at 0x40 still misses afterward.
- `load`=`store`=1 simultaneously at 0x10 → only a write is issued (`mem_we`=1); no fill request occurs.
